sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/mycpu_pkg.sv | 21 ++
 rtl/sram_id_fifo.sv | 49 ++++
 rtl/sram_arbiter.sv | 129 ++++++++++++
 tb/tb_sram_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared definitions for the SRAM-side bus blocks: transfer size encodings
// and default parameter values.
package mycpu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam int DEF_NUM_CH = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 4;

  // Index width that stays at least one bit wide.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_id_fifo.sv
// Ordered FIFO of channel IDs for issued-but-unanswered memory requests.
// The head is read combinationally so a response routes in the same cycle.
module sram_id_fifo
  import mycpu_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [W-1:0]               push_id,
  input  logic                       pop,
  output logic [W-1:0]               head_id,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr_reg;
  logic [PW-1:0] rptr_reg;
  logic [PW:0]   count_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wptr_reg] <= push_id;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + PW'(1);
      if (pop)  rptr_reg <= rptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_id = mem[rptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/sram_arbiter.sv
// N-channel arbiter onto one SRAM-like port with in-order response routing.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority.
module sram_arbiter
  import mycpu_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_wr,
  input  logic [2*NUM_CH-1:0]        ch_size,
  input  logic [ADDR_W*NUM_CH-1:0]   ch_addr,
  input  logic [DATA_W*NUM_CH-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_addr_ok,
  output logic [NUM_CH-1:0]          ch_data_ok,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       m_req,
  output logic                       m_wr,
  output logic [1:0]                 m_size,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  input  logic                       m_addr_ok,
  input  logic                       m_data_ok,
  input  logic [DATA_W-1:0]          m_rdata,
  output logic                       resp_err
);

  localparam int IDW = idx_w(NUM_CH);
  localparam int CW  = $clog2(DEPTH) + 1;

  logic [IDW-1:0] arb_idx;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] grant_reg;
  logic [IDW-1:0] head_id;
  logic           lock_reg;
  logic           resp_err_reg;
  logic [CW-1:0]  count;
  logic           full;
  logic           accept;
  logic           resp;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] prio_ptr_reg;
  logic [IDW:0]   cand;
  logic           found;

  // Scan channels starting at the priority pointer, wrapping at NUM_CH.
  always_comb begin
    arb_idx = prio_ptr_reg;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, prio_ptr_reg} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NUM_CH)) cand = cand - (IDW+1)'(NUM_CH);
      if (!found && ch_req[cand[IDW-1:0]]) begin
        arb_idx = cand[IDW-1:0];
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      prio_ptr_reg <= '0;
    else if (accept)
      prio_ptr_reg <= (grant == IDW'(NUM_CH - 1)) ? '0 : grant + IDW'(1);
  end
`else
  always_comb begin
    arb_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_req[i]) arb_idx = IDW'(i);
    end
  end
`endif

  // A stalled request keeps its grant until the memory accepts it.
  assign grant  = lock_reg ? grant_reg : arb_idx;
  assign full   = (count == CW'(DEPTH));
  assign m_req  = ((|ch_req) || lock_reg) && !full;
  assign accept = m_req && m_addr_ok;
  assign resp   = m_data_ok && (count != '0);

  assign m_wr     = ch_wr[grant];
  assign m_size   = ch_size[int'(grant)*2 +: 2];
  assign m_addr   = ch_addr[int'(grant)*ADDR_W +: ADDR_W];
  assign m_wdata  = ch_wdata[int'(grant)*DATA_W +: DATA_W];
  assign ch_rdata = m_rdata;
  assign resp_err = resp_err_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_addr_ok[gi] = accept && (grant == IDW'(gi));
    assign ch_data_ok[gi] = resp && (head_id == IDW'(gi));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_reg     <= 1'b0;
      grant_reg    <= '0;
      resp_err_reg <= 1'b0;
    end else begin
      if (accept) begin
        lock_reg <= 1'b0;
      end else if (m_req) begin
        lock_reg  <= 1'b1;
        grant_reg <= grant;
      end
      if (m_data_ok && (count == '0)) resp_err_reg <= 1'b1;
    end
  end

  sram_id_fifo #(
    .W     (IDW),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (grant),
    .pop     (resp),
    .head_id (head_id),
    .count   (count)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (NUM_CH=2, DEPTH=4): vector table plus
// reset and contention sequences.
module tb_sram_arbiter;

  logic        clk;
  logic        resetn;
  logic [1:0]  ch_req;
  logic [1:0]  ch_wr;
  logic [3:0]  ch_size;
  logic [63:0] ch_addr;
  logic [63:0] ch_wdata;
  logic [1:0]  ch_addr_ok;
  logic [1:0]  ch_data_ok;
  logic [31:0] ch_rdata;
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  sram_arbiter dut (
    .clk        (clk),
    .resetn     (resetn),
    .ch_req     (ch_req),
    .ch_wr      (ch_wr),
    .ch_size    (ch_size),
    .ch_addr    (ch_addr),
    .ch_wdata   (ch_wdata),
    .ch_addr_ok (ch_addr_ok),
    .ch_data_ok (ch_data_ok),
    .ch_rdata   (ch_rdata),
    .m_req      (m_req),
    .m_wr       (m_wr),
    .m_size     (m_size),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_addr_ok  (m_addr_ok),
    .m_data_ok  (m_data_ok),
    .m_rdata    (m_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic        maok;
    logic        mdok;
    logic [31:0] rdata;
    logic        e_mreq;
    logic        e_g;
    logic [1:0]  e_caok;
    logic [1:0]  e_cdok;
    logic        e_err;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic [1:0] req, logic maok, logic mdok, logic [31:0] rdata,
                              logic e_mreq, logic e_g, logic [1:0] e_caok,
                              logic [1:0] e_cdok, logic e_err);
    vec_t v;
    v.req = req; v.maok = maok; v.mdok = mdok; v.rdata = rdata;
    v.e_mreq = e_mreq; v.e_g = e_g; v.e_caok = e_caok; v.e_cdok = e_cdok; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 ns later, well clear of the rising edge.
  task automatic drive(input logic [1:0] req, input logic maok, input logic mdok,
                       input logic [31:0] rdata);
    @(negedge clk);
    ch_req    = req;
    m_addr_ok = maok;
    m_data_ok = mdok;
    m_rdata   = rdata;
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    ch_req    = 2'b00;
    ch_wr     = 2'b10;
    ch_size   = {2'd2, 2'd0};
    ch_addr   = {32'h0000_2000, 32'h0000_1000};
    ch_wdata  = {32'hBBBB_0001, 32'hAAAA_0000};
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    m_rdata   = '0;

    vecs[0]  = mk(2'b01, 1, 0, 32'h0,         1, 0, 2'b01, 2'b00, 0);
    vecs[1]  = mk(2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 0);
    vecs[2]  = mk(2'b00, 0, 1, 32'hDEADBEEF,  0, 0, 2'b00, 2'b01, 0);
    vecs[3]  = mk(2'b10, 0, 0, 32'h0,         1, 1, 2'b00, 2'b00, 0);
    vecs[4]  = mk(2'b11, 0, 0, 32'h0,         1, 1, 2'b00, 2'b00, 0);
    vecs[5]  = mk(2'b11, 0, 0, 32'h0,         1, 1, 2'b00, 2'b00, 0);
    vecs[6]  = mk(2'b11, 1, 0, 32'h0,         1, 1, 2'b10, 2'b00, 0);
    vecs[7]  = mk(2'b11, 1, 0, 32'h0,         1, 0, 2'b01, 2'b00, 0);
    vecs[8]  = mk(2'b01, 1, 0, 32'h0,         1, 0, 2'b01, 2'b00, 0);
    vecs[9]  = mk(2'b10, 1, 0, 32'h0,         1, 1, 2'b10, 2'b00, 0);
    vecs[10] = mk(2'b11, 1, 0, 32'h0,         0, 0, 2'b00, 2'b00, 0);
    vecs[11] = mk(2'b11, 1, 1, 32'h11111111,  0, 0, 2'b00, 2'b10, 0);
    vecs[12] = mk(2'b01, 0, 0, 32'h0,         1, 0, 2'b00, 2'b00, 0);
    vecs[13] = mk(2'b01, 1, 1, 32'h22222222,  1, 0, 2'b01, 2'b01, 0);
    vecs[14] = mk(2'b00, 0, 1, 32'h33333333,  0, 0, 2'b00, 2'b01, 0);
    vecs[15] = mk(2'b00, 0, 1, 32'h44444444,  0, 0, 2'b00, 2'b10, 0);
    vecs[16] = mk(2'b00, 0, 1, 32'h55555555,  0, 0, 2'b00, 2'b01, 0);
    vecs[17] = mk(2'b00, 0, 1, 32'h66666666,  0, 0, 2'b00, 2'b00, 0);
    vecs[18] = mk(2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 1);
    vecs[19] = mk(2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 1);

    // Reset state
    #2;
    chk("reset m_req", 32'(m_req), 32'd0);
    chk("reset ch_addr_ok", 32'(ch_addr_ok), 32'd0);
    chk("reset ch_data_ok", 32'(ch_data_ok), 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].req, vecs[i].maok, vecs[i].mdok, vecs[i].rdata);
      chk($sformatf("v%0d m_req", i), 32'(m_req), 32'(vecs[i].e_mreq));
      chk($sformatf("v%0d ch_addr_ok", i), 32'(ch_addr_ok), 32'(vecs[i].e_caok));
      chk($sformatf("v%0d ch_data_ok", i), 32'(ch_data_ok), 32'(vecs[i].e_cdok));
      chk($sformatf("v%0d resp_err", i), 32'(resp_err), 32'(vecs[i].e_err));
      if (vecs[i].e_mreq) begin
        chk($sformatf("v%0d m_addr", i), m_addr, vecs[i].e_g ? 32'h2000 : 32'h1000);
        chk($sformatf("v%0d m_wr", i), 32'(m_wr), 32'(vecs[i].e_g));
        chk($sformatf("v%0d m_size", i), 32'(m_size), vecs[i].e_g ? 32'd2 : 32'd0);
        chk($sformatf("v%0d m_wdata", i), m_wdata, vecs[i].e_g ? 32'hBBBB_0001 : 32'hAAAA_0000);
      end
      if (vecs[i].e_cdok != 2'b00)
        chk($sformatf("v%0d ch_rdata", i), ch_rdata, vecs[i].rdata);
      $display("vec %0d: req=%b aok=%b dok=%b m_req=%b m_addr=%h ch_addr_ok=%b ch_data_ok=%b err=%b",
               i, vecs[i].req, vecs[i].maok, vecs[i].mdok, m_req, m_addr,
               ch_addr_ok, ch_data_ok, resp_err);
    end

    // Reset mid-burst: outstanding IDs and sticky error are dropped at once.
    for (int i = 0; i < 2; i++) begin
      drive(2'b01, 1, 0, 32'h0);
      chk($sformatf("burst%0d ch_addr_ok", i), 32'(ch_addr_ok), 32'd1);
    end
    drive(2'b00, 0, 1, 32'hCAFE0000);
    resetn = 1'b0;
    #1;
    chk("async reset resp_err", 32'(resp_err), 32'd0);
    chk("async reset m_req", 32'(m_req), 32'd0);
    chk("async reset ch_data_ok", 32'(ch_data_ok), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    drive(2'b00, 0, 1, 32'hCAFE0001);
    chk("late resp ch_data_ok", 32'(ch_data_ok), 32'd0);
    drive(2'b00, 0, 0, 32'h0);
    chk("late resp resp_err", 32'(resp_err), 32'd1);
    $display("reset seq: resp_err=%b after late response", resp_err);

    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // Contention until the ID FIFO fills, then drain in issue order.
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      drive(2'b11, 1, 0, 32'h0);
      chk($sformatf("contend%0d ch_addr_ok", k), 32'(ch_addr_ok), 32'(exp_g));
      $display("contend %0d: ch_addr_ok=%b", k, ch_addr_ok);
    end
    drive(2'b11, 1, 0, 32'h0);
    chk("full m_req", 32'(m_req), 32'd0);
    chk("full ch_addr_ok", 32'(ch_addr_ok), 32'd0);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_d = 2'b01;
`endif
      drive(2'b00, 0, 1, 32'hA000_0000 + 32'(k));
      chk($sformatf("drain%0d ch_data_ok", k), 32'(ch_data_ok), 32'(exp_d));
      chk($sformatf("drain%0d ch_rdata", k), ch_rdata, 32'hA000_0000 + 32'(k));
      $display("drain %0d: ch_data_ok=%b rdata=%h", k, ch_data_ok, ch_rdata);
    end
    drive(2'b00, 0, 0, 32'h0);
    chk("drained resp_err", 32'(resp_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
